jump_target_table: RTL and testbench
====================================

// Module: jump_target_table
// PURPOSE
//   Programmable, parametrised successor to the fixed jump LUT: maps a branch pointer to a
//   PC target. Entries are written at run time (no hard-coded table), carry a valid bit and
//   an absolute/PC-relative mode bit, and are read with a registered one-cycle lookup.
//   Sits between the decoder (pointer field) and the PC/fetch unit; hit/miss counters feed debug.
// PARAMETERS
//   PTR_W   5    pointer width (table index)
//   DEPTH   32   number of entries, DEPTH <= 2**PTR_W
//   ADDR_W  12   PC / target width
//   CNT_W   16   width of saturating hit/miss counters
// PORTS
//   Clk        in   1       clock, all state updates on rising edge
//   Reset      in   1       synchronous, active-high; overrides every other input
//   flush      in   1       invalidate all entries this cycle
//   wr_en      in   1       write entry wr_ptr
//   wr_ptr     in   PTR_W   write index
//   wr_target  in   ADDR_W  absolute target, or two's-complement offset if wr_rel
//   wr_rel     in   1       1 = PC-relative entry, 0 = absolute
//   rd_en      in   1       lookup request
//   rd_ptr     in   PTR_W   lookup index
//   rd_pc      in   ADDR_W  PC of the branch, base for relative entries
//   rd_valid   out  1       lookup result valid (one-cycle pulse per request)
//   rd_hit     out  1       entry was valid
//   rd_target  out  ADDR_W  resolved jump target
//   hit_cnt    out  CNT_W   saturating count of hits
//   miss_cnt   out  CNT_W   saturating count of misses
// BEHAVIOUR
//   Reset: all valid bits 0, all targets 0, all rel bits 0; rd_valid=0, rd_hit=0,
//     rd_target=0, hit_cnt=0, miss_cnt=0. Reset asserted mid-lookup drops that result.
//   Write: wr_en at edge stores {valid=1, rel=wr_rel, target=wr_target} at wr_ptr.
//     wr_ptr >= DEPTH: write ignored, no state change.
//   Flush: clears every valid bit (targets retained, unobservable). flush+wr_en same cycle:
//     flush applied first, then the write -> written entry ends valid.
//   Lookup latency 1: rd_en in cycle N -> rd_valid=1 in cycle N+1 with rd_hit/rd_target.
//     Hit, rel=0: rd_target = target. Hit, rel=1: rd_target = (rd_pc + target) mod 2**ADDR_W
//     (wrap, no overflow flag). Miss (invalid entry or rd_ptr >= DEPTH): rd_hit=0, rd_target=0.
//   rd_en=0: rd_valid=0 next cycle; rd_hit/rd_target hold last values.
//   Same-cycle write and read of same index: write-first, lookup returns new entry.
//     Same-cycle flush and read: read sees miss unless same-cycle wr_en hits rd_ptr.
//   Counters: +1 on each completed lookup (hit_cnt on hit, miss_cnt on miss), update in the
//     cycle rd_valid rises; saturate at 2**CNT_W-1; cleared only by Reset, not by flush.
//   No state machine beyond table + one result register stage; back-to-back lookups every
//     cycle fully supported (throughput 1/cycle).
// TESTING
//   1 Reset, then rd_en ptr=3 -> next cycle rd_valid=1, rd_hit=0, rd_target=0, miss_cnt=1.
//   2 wr ptr=4 target=12'd139 rel=0; then rd ptr=4 -> rd_hit=1, rd_target=139, hit_cnt=1.
//   3 wr ptr=7 target=12'hFF0 (-16) rel=1; rd ptr=7 pc=12'd100 -> rd_target=84;
//     pc=12'd8 -> rd_target=12'hFF8 (wrap).
//   4 Same cycle wr ptr=2 target=77 and rd ptr=2 -> next cycle rd_hit=1, rd_target=77.
//   5 Fill ptrs 0..31, flush with wr ptr=5 target=10 -> rd 0..31: only ptr 5 hits (10);
//     DEPTH=24 build: wr/rd ptr=30 -> ignored / miss.
//   6 CNT_W=2: 5 hits -> hit_cnt=3 (saturates); Reset during pending lookup -> rd_valid=0,
//     counters 0.

Source files
------------

// File: rtl/jump_target_table.sv
// jump_target_table: programmable branch-pointer to PC-target table with a registered one-cycle lookup
// Ports: Clk/Reset (sync, active-high); flush clears all valid bits; wr_en/wr_ptr/wr_target/wr_rel
// write one entry; rd_en/rd_ptr/rd_pc request a lookup; rd_valid/rd_hit/rd_target return the
// result one cycle later; hit_cnt/miss_cnt are saturating lookup counters for debug.
module jump_target_table #(
    parameter int PTR_W  = 5,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [ADDR_W-1:0] wr_target,
    input  logic              wr_rel,
    input  logic              rd_en,
    input  logic [PTR_W-1:0]  rd_ptr,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic              rd_valid,
    output logic              rd_hit,
    output logic [ADDR_W-1:0] rd_target,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  rel;
    logic [ADDR_W-1:0] target [DEPTH];
    logic              wr_ok;
    logic              rd_ok;
    logic              fwd;
    logic              e_valid;
    logic              e_rel;
    logic [ADDR_W-1:0] e_tgt;
    // Lookup sees the table as it will be after this edge: flush first, then the write.
    always_comb begin
        wr_ok   = wr_en && 32'(wr_ptr) < DEPTH;
        rd_ok   = 32'(rd_ptr) < DEPTH;
        fwd     = wr_ok && wr_ptr == rd_ptr;
        e_valid = rd_ok && (fwd || (!flush && valid[rd_ptr]));
        e_rel   = fwd ? wr_rel : rel[rd_ptr];
        e_tgt   = fwd ? wr_target : target[rd_ptr];
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid     <= '0;
            rel       <= '0;
            for (int i = 0; i < DEPTH; i++) target[i] <= '0;
            rd_valid  <= 1'b0;
            rd_hit    <= 1'b0;
            rd_target <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            if (flush) valid <= '0;
            if (wr_ok) begin
                valid[wr_ptr]  <= 1'b1;
                rel[wr_ptr]    <= wr_rel;
                target[wr_ptr] <= wr_target;
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_hit    <= e_valid;
                rd_target <= !e_valid ? '0 : e_rel ? rd_pc + e_tgt : e_tgt;
                if (e_valid && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                if (!e_valid && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jump_target_table.sv
// tb_jump_target_table: scoreboard bench for jump_target_table (default, DEPTH=24 and CNT_W=2 builds)
module tb_jump_target_table;
    localparam int PTR_W  = 5;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              flush = 1'b0;
    logic              wr_en = 1'b0;
    logic [PTR_W-1:0]  wr_ptr = '0;
    logic [ADDR_W-1:0] wr_target = '0;
    logic              wr_rel = 1'b0;
    logic              rd_en = 1'b0;
    logic [PTR_W-1:0]  rd_ptr = '0;
    logic [ADDR_W-1:0] rd_pc = '0;

    logic              rd_valid, rd_hit;
    logic [ADDR_W-1:0] rd_target;
    logic [CNT_W-1:0]  hit_cnt, miss_cnt;
    logic              d_rd_valid, d_rd_hit;
    logic [ADDR_W-1:0] d_rd_target;
    logic [CNT_W-1:0]  d_hit_cnt, d_miss_cnt;
    logic              c_rd_valid, c_rd_hit;
    logic [ADDR_W-1:0] c_rd_target;
    logic [1:0]        c_hit_cnt, c_miss_cnt;

    jump_target_table u_dut (
        .Clk(Clk), .Reset(Reset), .flush(flush), .wr_en(wr_en), .wr_ptr(wr_ptr),
        .wr_target(wr_target), .wr_rel(wr_rel), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_pc(rd_pc),
        .rd_valid(rd_valid), .rd_hit(rd_hit), .rd_target(rd_target),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    jump_target_table #(.DEPTH(24)) u_d24 (
        .Clk(Clk), .Reset(Reset), .flush(flush), .wr_en(wr_en), .wr_ptr(wr_ptr),
        .wr_target(wr_target), .wr_rel(wr_rel), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_pc(rd_pc),
        .rd_valid(d_rd_valid), .rd_hit(d_rd_hit), .rd_target(d_rd_target),
        .hit_cnt(d_hit_cnt), .miss_cnt(d_miss_cnt)
    );

    jump_target_table #(.CNT_W(2)) u_c2 (
        .Clk(Clk), .Reset(Reset), .flush(flush), .wr_en(wr_en), .wr_ptr(wr_ptr),
        .wr_target(wr_target), .wr_rel(wr_rel), .rd_en(rd_en), .rd_ptr(rd_ptr), .rd_pc(rd_pc),
        .rd_valid(c_rd_valid), .rd_hit(c_rd_hit), .rd_target(c_rd_target),
        .hit_cnt(c_hit_cnt), .miss_cnt(c_miss_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic              hit;
        logic [ADDR_W-1:0] tgt;
    } exp_t;

    exp_t              q[$];
    exp_t              last_e = '0;
    logic              m_valid [32];
    logic              m_rel [32];
    logic [ADDR_W-1:0] m_tgt [32];
    int unsigned       m_hits = 0;
    int unsigned       m_miss = 0;
    int                checks = 0;
    int                failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_rel[i]   = 1'b0;
            m_tgt[i]   = '0;
        end
        m_hits = 0;
        m_miss = 0;
        q.delete();
        last_e = '0;
    endtask

    task automatic do_reset(input logic with_rd);
        Reset = 1'b1;
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = with_rd;
        rd_ptr = 5'd1;
        @(posedge Clk);
        #1;
        model_clear();
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_hit", 32'(rd_hit), 0);
        chk("rst_rd_target", 32'(rd_target), 0);
        chk("rst_hit_cnt", 32'(hit_cnt), 0);
        chk("rst_miss_cnt", 32'(miss_cnt), 0);
        chk("rst_c2_hit_cnt", 32'(c_hit_cnt), 0);
        Reset = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic step(input logic fl, input logic we, input int wp, input logic [ADDR_W-1:0] wt,
                        input logic wrl, input logic re, input int rp, input logic [ADDR_W-1:0] pc);
        exp_t e;
        flush     = fl;
        wr_en     = we;
        wr_ptr    = wp[PTR_W-1:0];
        wr_target = wt;
        wr_rel    = wrl;
        rd_en     = re;
        rd_ptr    = rp[PTR_W-1:0];
        rd_pc     = pc;
        if (fl) for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        if (we && wp < 32) begin
            m_valid[wp] = 1'b1;
            m_rel[wp]   = wrl;
            m_tgt[wp]   = wt;
        end
        if (re) begin
            e.hit = rp < 32 && m_valid[rp];
            e.tgt = !e.hit ? '0 : m_rel[rp] ? ADDR_W'(pc + m_tgt[rp]) : m_tgt[rp];
            q.push_back(e);
            if (e.hit && m_hits < 65535) m_hits++;
            if (!e.hit && m_miss < 65535) m_miss++;
        end
        @(posedge Clk);
        #1;
        chk("rd_valid", 32'(rd_valid), 32'(re));
        if (rd_valid) begin
            chk("sb_pending", q.size(), 1);
            if (q.size() > 0) last_e = q.pop_front();
        end
        chk("rd_hit", 32'(rd_hit), 32'(last_e.hit));
        chk("rd_target", 32'(rd_target), 32'(last_e.tgt));
        chk("hit_cnt", 32'(hit_cnt), m_hits);
        chk("miss_cnt", 32'(miss_cnt), m_miss);
    endtask

    initial begin
        do_reset(1'b0);
        // miss on empty table
        step(0, 0, 0, 0, 0, 1, 3, 0);
        // absolute entry
        step(0, 1, 4, 12'd139, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4, 0);
        chk("abs_target", 32'(rd_target), 139);
        // PC-relative entry with negative offset, including wrap
        step(0, 1, 7, 12'hFF0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 7, 12'd100);
        chk("rel_target", 32'(rd_target), 84);
        step(0, 0, 0, 0, 0, 1, 7, 12'd8);
        chk("rel_wrap", 32'(rd_target), 32'h0FF8);
        // same-cycle write and read, then idle hold
        step(0, 1, 2, 12'd77, 0, 1, 2, 0);
        chk("wr_first", 32'(rd_target), 77);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // fill, flush with concurrent write, sweep
        for (int i = 0; i < 32; i++) step(0, 1, i, ADDR_W'(i * 3 + 1), 0, 0, 0, 0);
        step(1, 1, 5, 12'd10, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 0, 1, i, 0);
            chk("d24_hit", 32'(d_rd_hit), 32'(i == 5));
        end
        // flush while reading: only the same-cycle write survives
        step(1, 1, 9, 12'd33, 0, 1, 9, 0);
        step(1, 0, 0, 0, 0, 1, 5, 0);
        // out-of-range index on the DEPTH=24 build
        step(0, 1, 30, 12'd55, 0, 1, 30, 0);
        chk("d24_oob_hit", 32'(d_rd_hit), 0);
        chk("d24_oob_target", 32'(d_rd_target), 0);
        step(0, 0, 0, 0, 0, 1, 30, 0);
        chk("d24_oob_valid", 32'(d_rd_valid), 1);
        chk("d24_oob_hit2", 32'(d_rd_hit), 0);
        // counter saturation on CNT_W=2 build
        do_reset(1'b0);
        step(0, 1, 1, 12'd9, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1, 0);
        chk("c2_hit_sat", 32'(c_hit_cnt), 3);
        chk("c2_miss", 32'(c_miss_cnt), 0);
        // reset with a lookup in flight drops the result
        do_reset(1'b1);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
